// File: rtl/debug_pkg.sv
// debug_pkg: FSM state and access-region types, plus the debug address map.
package debug_pkg;

  typedef enum logic [1:0] {
    RUNNING,
    HALT_REQ,
    HALTED,
    RESUMING
  } dbg_state_e;

  typedef enum logic [1:0] {
    REGION_NONE,
    REGION_CTRL,
    REGION_GPR,
    REGION_NPC
  } dbg_region_e;

  localparam logic [31:0] CTRL_ADDR = 32'h0000_0000;
  localparam logic [31:0] GPR_BASE  = 32'h0000_0400;
  // Word-offset bits that select one of the 32 GPRs inside the GPR window
  localparam logic [31:0] GPR_SPAN  = 32'h0000_007C;
  localparam logic [31:0] NPC_ADDR  = 32'h0000_2000;

  localparam int CTRL_HALTED_BIT = 16;
  localparam int GPR_IDX_W       = 5;

endpackage

// File: rtl/debug_addr_decode.sv
// debug_addr_decode: maps a debug byte address onto CTRL / GPR / NPC regions.
// The NPC region only exists when DEBUG_NPC_EN is defined.
module debug_addr_decode
  import debug_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic [ADDR_W-1:0]    addr_i,
  output dbg_region_e          region_o,
  output logic [GPR_IDX_W-1:0] gpr_idx_o
);

  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] gpr_window;

  always_comb begin
    word_addr  = addr_i & ~ADDR_W'(3);
    gpr_window = word_addr & ~ADDR_W'(GPR_SPAN);
    region_o   = REGION_NONE;
    if (word_addr == ADDR_W'(CTRL_ADDR)) begin
      region_o = REGION_CTRL;
    end else if (gpr_window == ADDR_W'(GPR_BASE)) begin
      region_o = REGION_GPR;
    end
`ifdef DEBUG_NPC_EN
    else if (word_addr == ADDR_W'(NPC_ADDR)) begin
      region_o = REGION_NPC;
    end
`endif
  end

  assign gpr_idx_o = addr_i[2 +: GPR_IDX_W];

endmodule

// File: rtl/debug_responder.sv
// debug_responder: halt/resume handshake with the core plus a single-outstanding debug
// access port onto CTRL and the GPR file. Define DEBUG_NPC_EN to add the NPC register.
module debug_responder
  import debug_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 debug_req_i,
  input  logic [ADDR_W-1:0]    debug_addr_i,
  input  logic                 debug_we_i,
  input  logic [DATA_W-1:0]    debug_wdata_i,
  input  logic                 debug_halt_i,
  input  logic                 debug_resume_i,
  output logic                 debug_gnt_o,
  output logic                 debug_rvalid_o,
  output logic [DATA_W-1:0]    debug_rdata_o,
  output logic                 debug_halted_o,
  output logic                 core_halt_req_o,
  input  logic                 core_halted_i,
  output logic [GPR_IDX_W-1:0] rf_addr_o,
  output logic                 rf_we_o,
  output logic [DATA_W-1:0]    rf_wdata_o,
  input  logic [DATA_W-1:0]    rf_rdata_i
`ifdef DEBUG_NPC_EN
  ,
  input  logic [DATA_W-1:0]    core_npc_i,
  output logic [DATA_W-1:0]    core_npc_o,
  output logic                 core_npc_we_o
`endif
);

  dbg_state_e           state_q, state_d;
  dbg_region_e          region;
  logic [GPR_IDX_W-1:0] gpr_idx;
  logic                 resp_pending_q, resp_pending_d;
  logic                 resume_held_q, resume_held_d;
  logic                 halted_q, halted_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [DATA_W-1:0]    ctrl_word;
  logic                 gnt;
  logic                 in_halted;
  logic                 resume_req;

  debug_addr_decode #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .addr_i    (debug_addr_i),
    .region_o  (region),
    .gpr_idx_o (gpr_idx)
  );

  // Reset masks the grant so an access presented during reset never produces a response.
  assign gnt       = debug_req_i & ~resp_pending_q & ~rst_i;
  assign in_halted = (state_q == HALTED);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUNNING;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    resume_held_d = 1'b0;
    resume_req    = debug_resume_i | resume_held_q;
    case (state_q)
      RUNNING: begin
        if (debug_halt_i) begin
          state_d = HALT_REQ;
        end
      end
      HALT_REQ: begin
        if (core_halted_i) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        // A resume racing a fresh grant waits until that access has returned its rvalid.
        if (resume_req) begin
          if (gnt) begin
            resume_held_d = 1'b1;
          end else begin
            state_d = RESUMING;
          end
        end
      end
      RESUMING: begin
        if (!core_halted_i) begin
          state_d = RUNNING;
        end
      end
      default: state_d = RUNNING;
    endcase
  end

  always_comb begin
    core_halt_req_o = (state_q == HALT_REQ) || (state_q == HALTED);
    halted_d        = (state_d == HALTED);
  end

  always_comb begin
    ctrl_word                  = '0;
    ctrl_word[CTRL_HALTED_BIT] = halted_q;
    rf_we_o                    = 1'b0;
    rdata_d                    = rdata_q;
    resp_pending_d             = gnt;
`ifdef DEBUG_NPC_EN
    core_npc_we_o              = 1'b0;
`endif
    if (gnt) begin
      rdata_d = '0;
      case (region)
        REGION_CTRL: begin
          if (!debug_we_i) begin
            rdata_d = ctrl_word;
          end
        end
        REGION_GPR: begin
          // x0 is hard-wired zero: writes are swallowed and reads return 0.
          if (in_halted && (gpr_idx != '0)) begin
            if (debug_we_i) begin
              rf_we_o = 1'b1;
            end else begin
              rdata_d = rf_rdata_i;
            end
          end
        end
`ifdef DEBUG_NPC_EN
        REGION_NPC: begin
          if (in_halted) begin
            if (debug_we_i) begin
              core_npc_we_o = 1'b1;
            end else begin
              rdata_d = core_npc_i;
            end
          end
        end
`endif
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_pending_q <= 1'b0;
      resume_held_q  <= 1'b0;
      halted_q       <= 1'b0;
      rdata_q        <= '0;
    end else begin
      resp_pending_q <= resp_pending_d;
      resume_held_q  <= resume_held_d;
      halted_q       <= halted_d;
      rdata_q        <= rdata_d;
    end
  end

  assign debug_gnt_o    = gnt;
  assign debug_rvalid_o = resp_pending_q;
  assign debug_rdata_o  = rdata_q;
  assign debug_halted_o = halted_q;
  assign rf_addr_o      = gpr_idx;
  assign rf_wdata_o     = debug_wdata_i;
`ifdef DEBUG_NPC_EN
  assign core_npc_o     = debug_wdata_i;
`endif

endmodule
